// File: rtl/main_fifo_reader_pkg.sv
// Shared constants for the main FIFO drain path: FSM state encoding and statistics counter width.
package main_fifo_reader_pkg;

  localparam int STATE_W = 2;
  localparam int STATS_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_IDLE   = 2'd3
  } state_t;

  // Saturating increment for the per-VC word counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/vc_word_router.sv
// Captures the word returned one cycle after a pop and steers it to VC0 or VC1 with a registered
// strobe; a word whose destination is full is dropped and latches a sticky overflow flag.
module vc_word_router #(
  parameter int DATA_WIDTH = 6,
  parameter int VC_BIT     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] main_data,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  output logic                  vc0_wr_en,
  output logic                  vc1_wr_en,
  output logic [DATA_WIDTH-1:0] vc_data,
  output logic                  overflow_error,
  output logic                  pending
);

  logic                  pending_reg;
  logic [1:0]            wr_en_reg;
  logic [1:0]            wr_hit;
  logic [1:0]            vc_full;
  logic [DATA_WIDTH-1:0] vc_data_reg;
  logic                  overflow_reg;
  logic                  sel;

  assign sel     = main_data[VC_BIT];
  assign vc_full = {vc1_full, vc0_full};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      assign wr_hit[gi] = pending_reg && (sel == 1'(gi)) && !vc_full[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg  <= 1'b0;
      wr_en_reg    <= 2'b00;
      vc_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg <= rd_en;
      wr_en_reg   <= wr_hit;
      if (|wr_hit) begin
        vc_data_reg <= main_data;
      end
      // Selected VC full: the word is lost, so remember it until the next reset.
      if (pending_reg && vc_full[sel]) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign vc0_wr_en      = wr_en_reg[0];
  assign vc1_wr_en      = wr_en_reg[1];
  assign vc_data        = vc_data_reg;
  assign overflow_error = overflow_reg;
  assign pending        = pending_reg;

endmodule

// File: rtl/main_fifo_reader.sv
// Main FIFO drain: FSM and pop gating, with word routing delegated to vc_word_router.
// Define MAIN_FIFO_READER_STATS_EN to add saturating per-VC word counters (vc0_count, vc1_count).
module main_fifo_reader
  import main_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int VC_BIT     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  main_empty,
  input  logic [DATA_WIDTH-1:0] main_data,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  output logic                  main_rd_en,
  output logic                  vc0_wr_en,
  output logic                  vc1_wr_en,
  output logic [DATA_WIDTH-1:0] vc_data,
  output logic                  idle,
  output logic                  overflow_error,
  output logic [STATE_W-1:0]    state
`ifdef MAIN_FIFO_READER_STATS_EN
  ,
  output logic [STATS_W-1:0]    vc0_count,
  output logic [STATS_W-1:0]    vc1_count
`endif
);

  state_t state_reg;
  state_t state_next;
  logic   pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RESET) begin
      state_next = ST_INIT;
    end else if (init) begin
      state_next = ST_INIT;
    end else begin
      case (state_reg)
        ST_INIT:   state_next = main_empty ? ST_IDLE : ST_ACTIVE;
        // Leave ACTIVE only once every popped word has been written out.
        ST_ACTIVE: if (main_empty && !pending && !vc0_wr_en && !vc1_wr_en) state_next = ST_IDLE;
        ST_IDLE:   if (!main_empty) state_next = ST_ACTIVE;
        default:   state_next = ST_INIT;
      endcase
    end
  end

  // Destination is unknown until the data returns, so either almost-full stalls the pop.
  assign main_rd_en = (state_reg == ST_ACTIVE) && !main_empty &&
                      !vc0_almost_full && !vc1_almost_full;
  assign idle  = (state_reg == ST_IDLE);
  assign state = state_reg;

  vc_word_router #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_BIT     (VC_BIT)
  ) u_router (
    .clk            (clk),
    .reset          (reset),
    .rd_en          (main_rd_en),
    .main_data      (main_data),
    .vc0_full       (vc0_full),
    .vc1_full       (vc1_full),
    .vc0_wr_en      (vc0_wr_en),
    .vc1_wr_en      (vc1_wr_en),
    .vc_data        (vc_data),
    .overflow_error (overflow_error),
    .pending        (pending)
  );

`ifdef MAIN_FIFO_READER_STATS_EN
  logic [STATS_W-1:0] vc0_count_reg;
  logic [STATS_W-1:0] vc1_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vc0_count_reg <= '0;
      vc1_count_reg <= '0;
    end else begin
      if (vc0_wr_en) vc0_count_reg <= sat_inc(vc0_count_reg);
      if (vc1_wr_en) vc1_count_reg <= sat_inc(vc1_count_reg);
    end
  end

  assign vc0_count = vc0_count_reg;
  assign vc1_count = vc1_count_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
